// File: rtl/alu_pkg.sv
// alu_pkg: opcode and state enums plus the illegal-result constant shared by alu_seq and alu_muldiv_iter
package alu_pkg;
  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLL  = 4'b1000,
    OP_SRL  = 4'b1001,
    OP_SRA  = 4'b1010,
    OP_MUL  = 4'b1100,
    OP_DIVU = 4'b1101,
    OP_REMU = 4'b1110
  } op_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  localparam logic [63:0] ILLEGAL_RESULT = '0;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: issue-side valid/ready request and writeback-side valid/ready result bundle
// master = issue/writeback side, slave = alu_seq
interface alu_seq_if #(parameter int WIDTH = 32);
  logic             InValid, InReady, OutValid, OutReady;
  logic             Zero, Overflow, Illegal;
  logic [WIDTH-1:0] A, B, Result;
  logic [3:0]       ALUControl;
  modport master (output InValid, A, B, ALUControl, OutReady,
                  input  InReady, OutValid, Result, Zero, Overflow, Illegal);
  modport slave  (input  InValid, A, B, ALUControl, OutReady,
                  output InReady, OutValid, Result, Zero, Overflow, Illegal);
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative shift-add multiply / restoring divide, one step per cycle (only built with ALU_MULDIV_EN)
// i_start loads operands; o_done pulses one cycle after the last step, o_result then holds product, quotient or remainder
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc, r_q, r_b;
  logic             r_mul, r_quot, r_done;
  logic [WIDTH:0]   w_sh, w_diff;
  // divide by zero falls out naturally: every trial subtract succeeds, so quotient is all ones and remainder is A
  assign w_sh   = {r_acc, r_q[WIDTH-1]};
  assign w_diff = w_sh - {1'b0, r_b};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_q    <= '0;
      r_b    <= '0;
      r_mul  <= 1'b0;
      r_quot <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_cnt  <= CNT_W'(WIDTH);
      r_acc  <= '0;
      r_q    <= i_a;
      r_b    <= i_b;
      r_mul  <= i_op == OP_MUL;
      r_quot <= i_op == OP_DIVU;
      r_done <= 1'b0;
    end else if (r_cnt != '0) begin
      r_cnt  <= r_cnt - CNT_W'(1);
      r_done <= r_cnt == CNT_W'(1);
      if (r_mul) begin
        r_acc <= r_acc + (r_q[0] ? r_b : '0);
        r_q   <= r_q >> 1;
        r_b   <= r_b << 1;
      end else begin
        r_acc <= w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
        r_q   <= {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
      end
    end else
      r_done <= 1'b0;
  assign o_done   = r_done;
  assign o_result = r_quot ? r_q : r_acc;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags; MUL/DIVU/REMU iterative when ALU_MULDIV_EN is defined
// clk, rst_n (async active-low); bus: alu_seq_if.slave (InValid/InReady/A/B/ALUControl in, OutValid/OutReady/Result/Zero/Overflow/Illegal out)
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);
  localparam int SH_W = $clog2(WIDTH);
  state_e           r_state, w_nxt;
  op_e              w_op;
  logic [WIDTH-1:0] r_result, w_res, w_sum, w_dif, w_md_res;
  logic             r_ovf, r_ill, w_ovf, w_ill, w_acc, w_md_op, w_md_done;
  logic [SH_W-1:0]  w_sh;
  assign w_op  = op_e'(bus.ALUControl);
  assign w_sh  = bus.B[SH_W-1:0];
  assign w_sum = bus.A + bus.B;
  assign w_dif = bus.A - bus.B;
  // a new op may enter in the same cycle the held result is taken
  assign bus.InReady = r_state == IDLE || (r_state == DONE && bus.OutReady);
  assign w_acc = bus.InValid && bus.InReady;
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_ill = 1'b0;
    case (w_op)
      OP_AND: w_res = bus.A & bus.B;
      OP_OR:  w_res = bus.A | bus.B;
      OP_XOR: w_res = bus.A ^ bus.B;
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = bus.A[WIDTH-1] == bus.B[WIDTH-1] && w_sum[WIDTH-1] != bus.A[WIDTH-1];
      end
      OP_SUB: begin
        w_res = w_dif;
        w_ovf = bus.A[WIDTH-1] != bus.B[WIDTH-1] && w_dif[WIDTH-1] != bus.A[WIDTH-1];
      end
      OP_SLT: w_res = WIDTH'($signed(bus.A) < $signed(bus.B));
      OP_SLL: w_res = bus.A << w_sh;
      OP_SRL: w_res = bus.A >> w_sh;
      OP_SRA: w_res = $signed(bus.A) >>> w_sh;
`ifdef ALU_MULDIV_EN
      OP_MUL, OP_DIVU, OP_REMU: ;
`endif
      default: begin
        w_res = WIDTH'(ILLEGAL_RESULT);
        w_ill = 1'b1;
      end
    endcase
  end
`ifdef ALU_MULDIV_EN
  assign w_md_op = w_op inside {OP_MUL, OP_DIVU, OP_REMU};
  alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_acc && w_md_op),
    .i_op     (w_op),
    .i_a      (bus.A),
    .i_b      (bus.B),
    .o_done   (w_md_done),
    .o_result (w_md_res)
  );
`else
  assign w_md_op   = 1'b0;
  assign w_md_done = 1'b0;
  assign w_md_res  = '0;
`endif
  always_comb begin
    w_nxt = r_state;
    if (w_acc) w_nxt = w_md_op ? BUSY : DONE;
    else if (r_state == DONE && bus.OutReady) w_nxt = IDLE;
    else if (r_state == BUSY && w_md_done) w_nxt = DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_ill    <= 1'b0;
    end else if (w_acc && !w_md_op) begin
      r_result <= w_res;
      r_ovf    <= w_ovf;
      r_ill    <= w_ill;
    end else if (r_state == BUSY && w_md_done) begin
      r_result <= w_md_res;
      r_ovf    <= 1'b0;
      r_ill    <= 1'b0;
    end
  assign bus.OutValid = r_state == DONE;
  assign bus.Result   = r_result;
  assign bus.Zero     = r_result == '0;
  assign bus.Overflow = r_ovf;
  assign bus.Illegal  = r_ill;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random ops against an arithmetic reference model of alu_seq
module tb_alu_seq;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  alu_seq_if #(.WIDTH(W)) bus();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_md(input logic [3:0] op);
`ifdef ALU_MULDIV_EN
    return op == 4'hC || op == 4'hD || op == 4'hE;
`else
    return 1'b0;
`endif
  endfunction

  // returns {illegal, overflow, result}
  function automatic logic [W+1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, s, lim;
    int sh;
    logic [W-1:0] r;
    bit ovf, ill;
    sa = $signed(a);
    sb = $signed(b);
    lim = longint'(1) << (W - 1);
    sh = int'(b % W);
    r = '0;
    ovf = 1'b0;
    ill = 1'b0;
    if (is_md(op)) begin
      if (op == 4'hC) r = a * b;
      else if (op == 4'hD) r = (b == 0) ? '1 : a / b;
      else r = (b == 0) ? a : a % b;
    end else
      case (op)
        4'h0: r = a & b;
        4'h1: r = a | b;
        4'h3: r = a ^ b;
        4'h2: begin s = sa + sb; r = a + b; ovf = s >= lim || s < -lim; end
        4'h6: begin s = sa - sb; r = a - b; ovf = s >= lim || s < -lim; end
        4'h7: r = (sa < sb) ? W'(1) : W'(0);
        4'h8: r = a << sh;
        4'h9: r = a >> sh;
        4'hA: r = W'(sa >>> sh);
        default: ill = 1'b1;
      endcase
    return {ill, ovf, r};
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W+1:0] e;
    int cyc;
    bit rdy_busy;
    e = model(op, a, b);
    @(negedge clk);
    chk({tag, ".inready"}, W'(bus.InReady), W'(1));
    bus.InValid = 1'b1;
    bus.ALUControl = op;
    bus.A = a;
    bus.B = b;
    bus.OutReady = 1'b0;
    @(negedge clk);
    bus.InValid = 1'b0;
    cyc = 1;
    rdy_busy = 1'b0;
    while (!bus.OutValid && cyc < 200) begin
      rdy_busy |= bus.InReady;
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".latency"}, W'(cyc), is_md(op) ? W'(W + 1) : W'(1));
    if (is_md(op)) chk({tag, ".busy_inready"}, W'(rdy_busy), W'(0));
    chk({tag, ".result"}, bus.Result, e[W-1:0]);
    chk({tag, ".zero"}, W'(bus.Zero), W'(e[W-1:0] == 0));
    chk({tag, ".ovf"}, W'(bus.Overflow), W'(e[W]));
    chk({tag, ".illegal"}, W'(bus.Illegal), W'(e[W+1]));
    bus.OutReady = 1'b1;
    @(negedge clk);
    bus.OutReady = 1'b0;
    chk({tag, ".release"}, W'(bus.OutValid), W'(0));
  endtask

  logic [3:0] b2b_op [3];
  logic [W-1:0] b2b_a [3];
  logic [W-1:0] b2b_b [3];

  initial begin
    logic [W+1:0] e;
    logic [W-1:0] held;
    bit stale;
    logic [3:0] op;
    logic [W-1:0] ra, rb;
    bus.InValid = 1'b0;
    bus.OutReady = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.ALUControl = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst.outvalid", W'(bus.OutValid), W'(0));
    chk("rst.result", bus.Result, W'(0));
    chk("rst.zero", W'(bus.Zero), W'(1));
    chk("rst.ovf", W'(bus.Overflow), W'(0));
    chk("rst.illegal", W'(bus.Illegal), W'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.inready", W'(bus.InReady), W'(1));

    run_op("add_ovf", 4'h2, 32'h7FFF_FFFF, 32'h1);
    run_op("sub_zero", 4'h6, 32'd5, 32'd5);
    run_op("mul", 4'hC, 32'h0001_0000, 32'h0001_0000);
    run_op("divu", 4'hD, 32'd100, 32'd7);
    run_op("remu", 4'hE, 32'd100, 32'd7);
    run_op("divu0", 4'hD, 32'd9, 32'd0);
    run_op("remu0", 4'hE, 32'd9, 32'd0);
    run_op("illegal", 4'hF, 32'h1234, 32'h5678);

    b2b_op = '{4'h7, 4'hA, 4'h3};
    b2b_a = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hA5A5_0F0F};
    b2b_b = '{32'h1, 32'h4, 32'h5A5A_FFFF};
    bus.OutReady = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = model(b2b_op[i-1], b2b_a[i-1], b2b_b[i-1]);
        chk("b2b.outvalid", W'(bus.OutValid), W'(1));
        chk("b2b.result", bus.Result, e[W-1:0]);
      end
      if (i < 3) begin
        chk("b2b.inready", W'(bus.InReady), W'(1));
        bus.InValid = 1'b1;
        bus.ALUControl = b2b_op[i];
        bus.A = b2b_a[i];
        bus.B = b2b_b[i];
      end else
        bus.InValid = 1'b0;
    end
    @(negedge clk);
    bus.OutReady = 1'b0;
    chk("b2b.idle", W'(bus.OutValid), W'(0));

    @(negedge clk);
    bus.InValid = 1'b1;
    bus.ALUControl = 4'h1;
    bus.A = 32'hF000_0000;
    bus.B = 32'h0000_000F;
    @(negedge clk);
    bus.ALUControl = 4'h3;
    bus.A = 32'h1111_1111;
    bus.B = 32'h2222_2222;
    held = bus.Result;
    chk("bp.first", held, 32'hF000_000F);
    repeat (5) begin
      @(negedge clk);
      chk("bp.stable", bus.Result, 32'hF000_000F);
      chk("bp.outvalid", W'(bus.OutValid), W'(1));
      chk("bp.inready", W'(bus.InReady), W'(0));
    end
    bus.OutReady = 1'b1;
    @(negedge clk);
    bus.InValid = 1'b0;
    chk("bp.next", bus.Result, 32'h3333_3333);
    chk("bp.next_valid", W'(bus.OutValid), W'(1));
    @(negedge clk);
    bus.OutReady = 1'b0;

    @(negedge clk);
    bus.InValid = 1'b1;
    bus.ALUControl = 4'hD;
    bus.A = 32'd100;
    bus.B = 32'd7;
    @(negedge clk);
    bus.InValid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.outvalid", W'(bus.OutValid), W'(0));
    chk("midrst.result", bus.Result, W'(0));
    chk("midrst.zero", W'(bus.Zero), W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.inready", W'(bus.InReady), W'(1));
    stale = 1'b0;
    repeat (40) begin
      @(negedge clk);
      stale |= bus.OutValid;
    end
    chk("midrst.stale", W'(stale), W'(0));

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 40));
        2: rb = ra;
        default: rb = $urandom;
      endcase
      run_op("rand", op, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the datapath's combinational ALU. It accepts one operation per valid/ready transfer and registers the result and flags. It extends the existing opcode set with XOR, SLT and shifts, and optionally with iterative multiply/divide. It sits between the decode/issue stage and writeback, and tolerates writeback back-pressure.

## Interface
- WIDTH, 32: operand/result width in bits (≥ 8, power of two).
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived, not overridden).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- InValid  in  1  operation offered.
- InReady  out  1  block can accept an operation this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- ALUControl  in  4  opcode.
- OutValid  out  1  result held on outputs.
- OutReady  in  1  consumer takes result this cycle.
- Result  out  WIDTH  registered result.
- Zero  out  1  Result == 0.
- Overflow  out  1  signed overflow (ADD/SUB only, else 0).
- Illegal  out  1  opcode unsupported in this build.

## Operation
- Opcodes:
  - 0010 ADD; 0110 SUB; 0000 AND; 0001 OR; 0011 XOR.
  - 0111 SLT: signed, result 1/0.
  - 1000 SLL, 1001 SRL, 1010 SRA: shift amount is B[$clog2(WIDTH)-1:0].
  - 1100 MUL: low WIDTH bits. 1101 DIVU: quotient. 1110 REMU: remainder.
  - All others: Result 0, Illegal 1.
- FSM states IDLE, BUSY, DONE.
  - IDLE: InReady=1. On InValid, capture operands and opcode. Single-cycle ops → DONE; MUL/DIVU/REMU → BUSY with counter=WIDTH.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIV) step per cycle; counter decrements; at counter==1 the final step commits → DONE.
  - DONE: OutValid=1; outputs stable until OutReady. On OutReady, if InValid is also high, accept the new op in the same cycle (InReady = OutReady in DONE); otherwise → IDLE.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH.
  - Overflow = operand signs equal (ADD) or differ (SUB) and result sign differs from A.
- Divide by zero: quotient = all ones, remainder = A; no error flag.
- Zero is computed from the registered Result, so it is valid whenever OutValid is high.
- Reset values: state IDLE, OutValid 0, Result 0, Zero 1, Overflow 0, Illegal 0, InReady 1 once reset is released.
- Reset mid-BUSY or mid-DONE aborts the operation; no result is produced.

## Timing
- Single-cycle op accepted at edge N: OutValid high from edge N+1. Sustains 1 op/cycle when OutReady is held high.
- MUL/DIVU/REMU accepted at edge N: OutValid high from edge N+WIDTH+1. InReady is low throughout BUSY.
- InValid in BUSY is ignored; the producer holds it.
- OutReady with OutValid low has no effect.
- Combinational paths in→out: InReady depends on OutReady only.

## Configuration
- ALU_MULDIV_EN defined: MUL/DIVU/REMU are implemented and the BUSY state exists.
- ALU_MULDIV_EN undefined:
  - 1100/1101/1110 behave as illegal: 1-cycle latency, Result 0, Illegal 1.
  - Multiplier/divider datapath and counter are removed.

## Structure
- Package alu_pkg holds:
  - the opcode enum (4 bits, values above);
  - the state enum;
  - a localparam for the illegal-result value.
- Sub-module alu_muldiv_iter (compiled only under ALU_MULDIV_EN) holds:
  - the iterative multiply/divide datapath;
  - a start/done handshake to the parent FSM.
- The combinational op set stays in the top-level.

## Test plan
- Reset: assert rst_n=0 mid-DIVU → OutValid 0, Result 0, Zero 1; after release InReady 1, no stale result appears.
- ADD 0x7FFFFFFF+1 → Result 0x80000000, Overflow 1, 1-cycle latency. SUB 5-5 → Result 0, Zero 1.
- Back-to-back SLT(-1,1), SRA(0x80000000,4), XOR with OutReady=1 → Result 1, 0xF8000000, correct XOR on consecutive cycles; no bubbles.
- MUL 0x10000×0x10000 → Result 0 after 33 cycles. DIVU 100/7 → 14; REMU 100/7 → 2; InReady low throughout BUSY.
- DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9.
- Back-pressure: OutReady=0 for 5 cycles in DONE → Result/flags stable, InReady 0. Then opcode 1111 → Illegal 1, Result 0. Without ALU_MULDIV_EN, MUL → Illegal 1 in 1 cycle.
